udp_ip_tx_framer: RTL

UDP_IP_TX_FRAMER -- requirements
Module: udp_ip_tx_framer

---
 rtl/udp_ip_tx_framer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/udp_ip_tx_framer.sv
// UDP-to-IP transmit framer: turns a UDP header plus payload stream into an IP
// header and an IP payload stream that begins with the 8-byte UDP header.
module udp_ip_tx_framer #(
    parameter logic [7:0] TTL = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [31:0] s_udp_ip_source_ip,
    input  logic [31:0] s_udp_ip_dest_ip,
    input  logic [15:0] s_udp_source_port,
    input  logic [15:0] s_udp_dest_port,
    input  logic [15:0] s_udp_length,
    input  logic [15:0] s_udp_checksum,
    input  logic [7:0]  s_udp_payload_axis_tdata,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,
    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [15:0] m_ip_length,
    output logic [7:0]  m_ip_ttl,
    output logic [7:0]  m_ip_protocol,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        m_ip_payload_axis_tuser,
    output logic        busy,
    output logic        error_payload_early_termination
);

    typedef enum logic [2:0] {IDLE, HDR, UDP_HDR, PAYLOAD, DRAIN} state_t;

    state_t      state, state_next;
    logic [15:0] cnt, cnt_next;
    logic [31:0] source_ip_r, dest_ip_r;
    logic [15:0] source_port_r, dest_port_r, length_r, checksum_r;
    logic        hdr_fire, short_pkt, final_beat, in_fire;

    assign hdr_fire   = s_udp_hdr_valid && s_udp_hdr_ready;
    assign short_pkt  = (length_r <= 16'd8);
    // cnt counts payload bytes from 0, so the last one is index length-9
    assign final_beat = (cnt == length_r - 16'd9);
    assign in_fire    = s_udp_payload_axis_tvalid && m_ip_payload_axis_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            source_ip_r   <= '0;
            dest_ip_r     <= '0;
            source_port_r <= '0;
            dest_port_r   <= '0;
            length_r      <= '0;
            checksum_r    <= '0;
        end else if (hdr_fire) begin
            source_ip_r   <= s_udp_ip_source_ip;
            dest_ip_r     <= s_udp_ip_dest_ip;
            source_port_r <= s_udp_source_port;
            dest_port_r   <= s_udp_dest_port;
            length_r      <= s_udp_length;
            checksum_r    <= s_udp_checksum;
        end
    end

    always_comb begin
        state_next                      = state;
        cnt_next                        = cnt;
        s_udp_hdr_ready                 = 1'b0;
        m_ip_hdr_valid                  = 1'b0;
        s_udp_payload_axis_tready       = 1'b0;
        m_ip_payload_axis_tdata         = '0;
        m_ip_payload_axis_tvalid        = 1'b0;
        m_ip_payload_axis_tlast         = 1'b0;
        m_ip_payload_axis_tuser         = 1'b0;
        error_payload_early_termination = 1'b0;
        case (state)
            IDLE: begin
                s_udp_hdr_ready = !rst;
                if (s_udp_hdr_valid && !rst) state_next = HDR;
            end
            HDR: begin
                m_ip_hdr_valid = 1'b1;
                if (m_ip_hdr_ready) begin
                    cnt_next   = '0;
                    state_next = UDP_HDR;
                end
            end
            UDP_HDR: begin
                m_ip_payload_axis_tvalid = 1'b1;
                case (cnt[2:0])
                    3'd0: m_ip_payload_axis_tdata = source_port_r[15:8];
                    3'd1: m_ip_payload_axis_tdata = source_port_r[7:0];
                    3'd2: m_ip_payload_axis_tdata = dest_port_r[15:8];
                    3'd3: m_ip_payload_axis_tdata = dest_port_r[7:0];
                    3'd4: m_ip_payload_axis_tdata = length_r[15:8];
                    3'd5: m_ip_payload_axis_tdata = length_r[7:0];
                    3'd6: m_ip_payload_axis_tdata = checksum_r[15:8];
                    3'd7: m_ip_payload_axis_tdata = checksum_r[7:0];
                endcase
                m_ip_payload_axis_tlast = (cnt[2:0] == 3'd7) && short_pkt;
                if (m_ip_payload_axis_tready) begin
                    cnt_next = cnt + 16'd1;
                    if (cnt[2:0] == 3'd7) begin
                        cnt_next   = '0;
                        state_next = short_pkt ? IDLE : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                m_ip_payload_axis_tdata   = s_udp_payload_axis_tdata;
                m_ip_payload_axis_tvalid  = s_udp_payload_axis_tvalid;
                s_udp_payload_axis_tready = m_ip_payload_axis_tready;
                m_ip_payload_axis_tlast   = s_udp_payload_axis_tlast || final_beat;
                // an input tlast arriving before the count is reached marks the frame bad
                m_ip_payload_axis_tuser   = s_udp_payload_axis_tuser ||
                                            (s_udp_payload_axis_tlast && !final_beat);
                if (in_fire) begin
                    cnt_next = cnt + 16'd1;
                    if (final_beat) begin
                        state_next = s_udp_payload_axis_tlast ? IDLE : DRAIN;
                    end else if (s_udp_payload_axis_tlast) begin
                        error_payload_early_termination = 1'b1;
                        state_next                      = IDLE;
                    end
                end
            end
            DRAIN: begin
                s_udp_payload_axis_tready = 1'b1;
                if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign m_ip_length    = length_r + 16'd20;
    assign m_ip_ttl       = TTL;
    assign m_ip_protocol  = 8'h11;
    assign m_ip_source_ip = source_ip_r;
    assign m_ip_dest_ip   = dest_ip_r;
    assign m_ip_dscp      = '0;
    assign m_ip_ecn       = '0;
    assign busy           = (state != IDLE);

endmodule
